// File: rtl/mult_sequencer_pkg.sv
//==============================================================================
// Module      : mult_sequencer_pkg
// Description : Mode encodings and FSM state type for the iterative multiplier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package mult_sequencer_pkg;

  localparam logic [1:0] MULT_MODE_LO  = 2'b00;
  localparam logic [1:0] MULT_MODE_UHI = 2'b01;
  localparam logic [1:0] MULT_MODE_SHI = 2'b10;

  typedef enum logic [1:0] {
    MULT_ST_IDLE = 2'b00,
    MULT_ST_BUSY = 2'b01,
    MULT_ST_DONE = 2'b10
  } mult_state_e;

endpackage

`default_nettype wire

// File: rtl/mult_step.sv
//==============================================================================
// Module      : mult_step
// Description : One shift-add iteration over the {hi,lo} product register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mult_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, mcand_i} : '0);
    // Carry-out of the add lands in the top of hi after the right shift.
    hi_o  = w_sum[WIDTH:1];
    lo_o  = {w_sum[0], lo_i[WIDTH-1:1]};
  end

endmodule

`default_nettype wire

// File: rtl/mult_sequencer.sv
//==============================================================================
// Module      : mult_sequencer
// Description : WIDTH-cycle shift-add multiplier serving MUL, UMULH and SMULH.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int                CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  mult_state_e      state_q,  state_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [1:0]       mode_q,   mode_d;
  logic             sign_q,   sign_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             w_signed_req;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .mcand_i (mcand_q),
    .hi_o    (w_step_hi),
    .lo_o    (w_step_lo)
  );

  // The signed minimum maps to 2^(WIDTH-1), which fits as an unsigned magnitude.
  assign w_signed_req = (mode == MULT_MODE_SHI);
  assign w_mag_a      = (w_signed_req && op_a[WIDTH-1]) ? (~op_a + ONE_W) : op_a;
  assign w_mag_b      = (w_signed_req && op_b[WIDTH-1]) ? (~op_b + ONE_W) : op_b;
  assign w_prod       = {w_step_hi, w_step_lo};
  assign w_prod_fix   = sign_q ? (~w_prod + ONE_2W) : w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MULT_ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
      mode_q   <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    count_d  = count_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    result_d = result_q;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      MULT_ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          sign_d  = w_signed_req & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          hi_d    = '0;
          lo_d    = w_mag_b;
          mcand_d = w_mag_a;
          count_d = '0;
          state_d = MULT_ST_BUSY;
        end
      end
      MULT_ST_BUSY: begin
        busy    = 1'b1;
        hi_d    = w_step_hi;
        lo_d    = w_step_lo;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          unique case (mode_q)
            MULT_MODE_UHI,
            MULT_MODE_SHI: result_d = w_prod_fix[2*WIDTH-1:WIDTH];
            default:       result_d = w_prod_fix[WIDTH-1:0];
          endcase
          state_d = MULT_ST_DONE;
        end
      end
      MULT_ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = MULT_ST_IDLE;
      end
      default: state_d = MULT_ST_IDLE;
    endcase
  end

  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
//==============================================================================
// Module      : tb_mult_sequencer
// Description : Self-checking bench for mult_sequencer against a 128-bit model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mult_sequencer;

  localparam int         W    = 64;
  localparam logic [1:0] M_LO  = 2'b00;
  localparam logic [1:0] M_UHI = 2'b01;
  localparam logic [1:0] M_SHI = 2'b10;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode  = 2'b00;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Full-width product computed directly from the arithmetic definition.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] m, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic        [2*W-1:0] p;
    logic signed [2*W-1:0] sp;
    if (m == M_SHI) begin
      sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      return sp[2*W-1:W];
    end
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (m == M_UHI) return p[2*W-1:W];
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called at #1 after a clock edge with the DUT idle.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit disturb);
    int n;
    int busy_cnt;
    start = 1'b1;
    mode  = m;
    op_a  = a;
    op_b  = b;
    @(posedge clk); #1;
    busy_cnt = 0;
    for (n = 0; n < W + 8; n++) begin
      if (busy) busy_cnt++;
      if (done) break;
      if (disturb) begin
        start = 1'b1;
        mode  = 2'($urandom);
        op_a  = {$urandom, $urandom};
        op_b  = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "/latency"}, W'(n), W'(W));
    check_eq({tag, "/result"}, result, exp);
    check_eq({tag, "/busy_cycles"}, W'(busy_cnt), W'(W + 1));
    @(posedge clk); #1;
    check_eq({tag, "/done_pulse"}, W'(done), '0);
    check_eq({tag, "/idle_busy"}, W'(busy), '0);
    check_eq({tag, "/held"}, result, exp);
    if (!disturb) start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           seen;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/busy", W'(busy), '0);
    check_eq("rst/done", W'(done), '0);
    check_eq("rst/result", result, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_3x5", M_LO, 64'd3, 64'd5, 64'd15, 1'b0);
    run_op("umulh_ones", M_UHI, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("mul_ones", M_LO, '1, '1, 64'h0000_0000_0000_0001, 1'b0);
    run_op("smulh_m2x3", M_SHI, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("smulh_m1xm1", M_SHI, '1, '1, 64'h0, 1'b0);
    run_op("smulh_min", M_SHI, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 1'b0);
    run_op("disturb", M_LO, 64'd1234, 64'd5678, 64'd7006652, 1'b1);
    run_op("after_disturb", M_UHI, 64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0,
           ref_mul(M_UHI, 64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0), 1'b0);
    run_op("mode11_7x6", 2'b11, 64'd7, 64'd6, 64'd42, 1'b0);

    // Reset sampled at the 30th edge after the start edge.
    start = 1'b1; mode = M_LO; op_a = 64'd100; op_b = 64'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst/busy", W'(busy), '0);
    check_eq("midrst/done", W'(done), '0);
    check_eq("midrst/result", result, '0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check_eq("midrst/no_done", W'(seen), '0);

    // Reset and start together: start must not be accepted.
    reset = 1'b1; start = 1'b1; mode = M_LO; op_a = 64'd9; op_b = 64'd9;
    @(posedge clk); #1;
    check_eq("rst_start/busy", W'(busy), '0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_start/still_idle", W'(busy), '0);

    run_op("fresh_after_rst", M_LO, 64'd100, 64'd200, 64'd20000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom);
      a = rnd_op();
      b = rnd_op();
      run_op($sformatf("rand%0d_m%0d", i, m), m, a, b, ref_mul(m, a, b), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
